// File: rtl/relu_pool_q8.sv
// ReLU, non-overlapping max-pool and shift/saturate requantizer for the conv engine y stream.
// One output register with valid/ready; windows never span two VEC_LEN-sample vectors.
module relu_pool_q8 #(
  parameter int IN_W    = 21,
  parameter int OUT_W   = 8,
  parameter int POOL    = 2,
  parameter int VEC_LEN = 97,
  parameter int SHIFT   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  s_data_in_y,
  input  logic             s_valid_y,
  output logic             s_ready_y,
  output logic [OUT_W-1:0] m_data_out_z,
  output logic             m_valid_z,
  input  logic             m_ready_z,
  output logic             m_last_z
);

  localparam int WIN_W = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int VEC_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(POOL - 1);
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(VEC_LEN - 1);

  logic [WIN_W-1:0] r_win_cnt;
  logic [VEC_W-1:0] r_vec_cnt;
  logic [IN_W-2:0]  r_acc;
  logic [OUT_W-1:0] r_data;
  logic             r_valid;
  logic             r_last;

  logic [IN_W-2:0]  w_relu;
  logic [IN_W-2:0]  w_max;
  logic [IN_W-2:0]  w_shifted;
  logic [OUT_W-1:0] w_q;
  logic             w_vec_end;
  logic             w_closing_pos;
  logic             w_in_xfer;
  logic             w_close;

  assign w_relu    = s_data_in_y[IN_W-1] ? '0 : s_data_in_y[IN_W-2:0];
  assign w_max     = ((r_win_cnt == '0) || (w_relu > r_acc)) ? w_relu : r_acc;
  assign w_shifted = w_max >> SHIFT;
  assign w_q       = (|w_shifted[IN_W-2:OUT_W]) ? '1 : w_shifted[OUT_W-1:0];

  // Ready is a function of position and output occupancy only, never of valid or data.
  assign w_vec_end     = (r_vec_cnt == VEC_LAST);
  assign w_closing_pos = (r_win_cnt == WIN_LAST) || w_vec_end;
  assign s_ready_y     = !(w_closing_pos && r_valid && !m_ready_z);
  assign w_in_xfer     = s_valid_y && s_ready_y;
  assign w_close       = w_in_xfer && w_closing_pos;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_cnt <= '0;
      r_vec_cnt <= '0;
      r_acc     <= '0;
    end else if (w_in_xfer) begin
      r_acc <= w_max;
      if (w_closing_pos) begin
        r_win_cnt <= '0;
        r_vec_cnt <= w_vec_end ? '0 : r_vec_cnt + 1'b1;
      end else begin
        r_win_cnt <= r_win_cnt + 1'b1;
        r_vec_cnt <= r_vec_cnt + 1'b1;
      end
    end
  end

  // A close while the register drains reloads it in the same edge, so no bubble appears.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_close) begin
      r_data  <= w_q;
      r_valid <= 1'b1;
      r_last  <= w_vec_end;
    end else if (r_valid && m_ready_z) begin
      r_valid <= 1'b0;
    end
  end

  assign m_data_out_z = r_data;
  assign m_valid_z    = r_valid;
  assign m_last_z     = r_last;

endmodule

// File: doc/relu_pool_q8.md
# relu_pool_q8

Output post-processing stage sitting directly downstream of the 128x32 convolution engine. It consumes the engine's 21-bit signed `y` stream through a valid/ready handshake and applies three steps: ReLU, non-overlapping max-pooling over `POOL` consecutive samples within each 97-sample output vector, and requantization (arithmetic right shift, unsigned saturation) to `OUT_W` bits. It emits one quantized value per pooling window, with a `last` flag on the final window of each vector.

## Interface
- `IN_W`, 21: input sample width (signed).
- `OUT_W`, 8: output width (unsigned).
- `POOL`, 2: pooling window length in samples; legal range 1..8.
- `VEC_LEN`, 97: samples per input vector (N-M+1).
- `SHIFT`, 4: right-shift applied before saturation; legal range 0..IN_W-1.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `s_data_in_y`  in  IN_W  signed convolution result.
- `s_valid_y`  in  1  input sample valid.
- `s_ready_y`  out  1  block can accept a sample this cycle.
- `m_data_out_z`  out  OUT_W  pooled, quantized result.
- `m_valid_z`  out  1  output register holds a result.
- `m_ready_z`  in  1  downstream accepts the result.
- `m_last_z`  out  1  result is the final window of a vector.

## Operation
- Input transfer occurs when `s_valid_y && s_ready_y` at a rising edge. Output transfer occurs when `m_valid_z && m_ready_z`.
- ReLU: `r = (y < 0) ? 0 : y`.
- Running max `acc` (IN_W-1 bits, unsigned) is updated on each accepted sample: `acc <= (win_cnt==0) ? r : max(acc, r)`.
- Counters:
  - `win_cnt` runs 0..POOL-1 and counts the position within the window.
  - `vec_cnt` runs 0..VEC_LEN-1 and counts the position within the vector.
  - Both advance only on an input transfer.
- A window closes on an accepted sample when `win_cnt==POOL-1` or `vec_cnt==VEC_LEN-1`.
- On close:
  - `win_cnt <= 0`.
  - `vec_cnt` wraps to 0 if it was at VEC_LEN-1, otherwise it increments.
  - The output register loads `q = sat(max(acc_or_r) >> SHIFT)`, where `sat` clamps to 2^OUT_W-1.
  - `m_last_z` loads 1 iff `vec_cnt==VEC_LEN-1`.
  - `m_valid_z <= 1`.
- A vector yields ceil(VEC_LEN/POOL) outputs; with defaults that is 49, and the 49th window contains one sample. Windows never span two vectors.
- States are implied by the counters plus `m_valid_z`:
  - EMPTY: `m_valid_z=0`.
  - FULL: `m_valid_z=1`.
  - A close while FULL with `m_ready_z=1` in the same cycle reloads the register and stays FULL; the old value transfers and the new one loads with no bubble.
  - A transfer with no close goes FULL to EMPTY.
- Backpressure: `s_ready_y = !(closing_pos && m_valid_z && !m_ready_z)`, where `closing_pos` is computed from counters only.
  - Non-closing samples are always accepted.
  - `s_ready_y` never depends on `s_valid_y` or on data.
- While `m_valid_z=1 && m_ready_z=0`, `m_data_out_z` and `m_last_z` are held stable.
- Input data is ignored (X-tolerant) when `s_valid_y=0`.

## Timing
- Reset values:
  - `m_valid_z=0`, `m_data_out_z=0`, `m_last_z=0`.
  - `win_cnt=0`, `vec_cnt=0`, `acc=0`.
  - `s_ready_y=1` in the cycle after reset deasserts.
- Latency: the result is visible (`m_valid_z=1`) in the cycle after the closing sample's transfer edge.
- Throughput: one input per cycle sustained when `m_ready_z=1`.
- Reset mid-vector discards the partial window and any undelivered output. The next accepted sample is position 0 of a new vector.
- Arithmetic: compare in IN_W-bit signed; the shift is logical on the nonnegative value; saturation is applied after the shift. No rounding (truncate).

## Test plan
- POOL=2, SHIFT=4, `m_ready_z=1`: y=100, -50 → z=6 one cycle after the 2nd transfer, `m_last_z=0`.
- Saturation and ReLU: y=5000, 4999 → z=255; y=-7, -1 → z=0; y=15, 16 → z=1.
- Vector boundary: stream 97 samples of value 32·k (k=index) → 49 outputs. Output 49 equals sat(3072>>4)=192 with `m_last_z=1`. Outputs 1..48 have `m_last_z=0`. Sample 98 starts a new window.
- Backpressure: hold `m_ready_z=0` after output 1 → `m_data_out_z` stable; `s_ready_y` drops only at the next closing sample. Release `m_ready_z` → zero lost or duplicated values versus the reference model over 10 vectors with random valid/ready.
- Simultaneous drain and close: FULL register, `m_ready_z=1` in the same cycle as a closing transfer → `m_valid_z` stays 1, the new value is present next cycle, with no bubble.
- Reset after 50 samples → all outputs return to reset values. The next 97 samples produce exactly 49 outputs, the last flagged.
